// File: rtl/idu_pipe_stage.sv
// rtl/idu_pipe_stage.sv - Registered RV32I decode stage with optional 2-entry skid buffer
//
// Purpose: decodes one instruction word + PC per valid/ready beat into a
//   registered bundle one cycle later. Decoding happens on the input side;
//   the buffer stores already-decoded bundles.
// Ports:
//   i_clk, i_rst_n           clock (rising edge), asynchronous active-low reset
//   i_flush                  synchronous kill of all buffered entries
//   i_in_valid / o_in_ready  upstream handshake; i_in_inst, i_in_pc beat payload
//   o_out_valid / i_out_ready downstream handshake
//   o_out_pc, o_d0en, o_s1en, o_s2en, o_d0imm, o_s1, o_s2imm,
//   o_fun, o_opcode, o_itype, o_use_alu, o_illegal   decoded bundle
//   o_dec_cnt                count of bundles handed downstream (wraps)
module idu_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_inst,
  input  logic [WIDTH-1:0] i_in_pc,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_pc,
  output logic             o_d0en,
  output logic             o_s1en,
  output logic             o_s2en,
  output logic [WIDTH-1:0] o_d0imm,
  output logic [WIDTH-1:0] o_s1,
  output logic [WIDTH-1:0] o_s2imm,
  output logic [9:0]       o_fun,
  output logic [6:0]       o_opcode,
  output logic [5:0]       o_itype,
  output logic             o_use_alu,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_dec_cnt
);

  localparam int BW = 4*WIDTH + 28;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input-side decode
  // ---------------------------------------------------------------------------
  logic [6:0]        w_op;
  logic              w_is_r, w_is_ialu, w_is_sys, w_is_i, w_is_u;
  logic              w_is_s, w_is_b, w_is_j, w_f7_ok, w_illegal;
  logic              w_d0en, w_s1en, w_s2en, w_use_alu;
  logic [5:0]        w_itype;
  logic [9:0]        w_fun;
  logic [WIDTH-1:0]  w_rd, w_rs1, w_rs2;
  logic [WIDTH-1:0]  w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [WIDTH-1:0]  w_d0imm, w_s1, w_s2imm;
  logic signed [11:0] w_i12, w_s12;
  logic signed [12:0] w_b13;
  logic signed [20:0] w_j21;
  logic signed [31:0] w_u32;
  logic [BW-1:0]     w_dec;

  assign w_op      = i_in_inst[6:0];
  assign w_is_r    = (w_op == 7'b0110011);
  assign w_is_ialu = (w_op == 7'b0010011);
  assign w_is_sys  = (w_op == 7'b1110011);
  assign w_is_i    = w_is_ialu | (w_op == 7'b0000011) | (w_op == 7'b1100111) | w_is_sys;
  assign w_is_u    = (w_op == 7'b0110111) | (w_op == 7'b0010111);
  assign w_is_s    = (w_op == 7'b0100011);
  assign w_is_b    = (w_op == 7'b1100011);
  assign w_is_j    = (w_op == 7'b1101111);
  assign w_f7_ok   = (i_in_inst[31:25] == 7'b0000000) | (i_in_inst[31:25] == 7'b0100000);

  // Every listed opcode ends in 2'b11, so an unlisted opcode also covers bad low bits.
  assign w_illegal = ~(w_is_r | w_is_i | w_is_u | w_is_s | w_is_b | w_is_j) |
                     (w_is_r & ~w_f7_ok);

  // Signed locals so the size casts below sign-extend to WIDTH.
  assign w_i12 = i_in_inst[31:20];
  assign w_s12 = {i_in_inst[31:25], i_in_inst[11:7]};
  assign w_b13 = {i_in_inst[31], i_in_inst[7], i_in_inst[30:25], i_in_inst[11:8], 1'b0};
  assign w_j21 = {i_in_inst[31], i_in_inst[19:12], i_in_inst[20], i_in_inst[30:21], 1'b0};
  assign w_u32 = {i_in_inst[31:12], 12'b0};

  assign w_imm_i = WIDTH'(w_i12);
  assign w_imm_s = WIDTH'(w_s12);
  assign w_imm_b = WIDTH'(w_b13);
  assign w_imm_j = WIDTH'(w_j21);
  assign w_imm_u = WIDTH'(w_u32);

  assign w_rd  = WIDTH'(i_in_inst[11:7]);
  assign w_rs1 = WIDTH'(i_in_inst[19:15]);
  assign w_rs2 = WIDTH'(i_in_inst[24:20]);

  // Stores and branches have no destination; SYSTEM carries neither rd nor rs1.
  assign w_d0en    = ~w_illegal & ~w_is_s & ~w_is_b & ~w_is_sys;
  assign w_s1en    = ~w_illegal & ~w_is_j & ~w_is_sys;
  assign w_s2en    = ~w_illegal & (w_is_r | w_is_s | w_is_b);
  assign w_use_alu = ~w_illegal & (w_is_r | w_is_ialu);
  assign w_itype   = w_illegal ? 6'b0 : {w_is_r, w_is_i, w_is_s, w_is_b, w_is_u, w_is_j};
  assign w_fun     = {i_in_inst[14:12], i_in_inst[31:25]};

  always_comb begin
    w_d0imm = '0;
    w_s2imm = '0;
    if (!w_illegal) begin
      if (w_d0en)      w_d0imm = w_rd;
      else if (w_is_s) w_d0imm = w_imm_s;
      else if (w_is_b) w_d0imm = w_imm_b;

      if (w_s2en)      w_s2imm = w_rs2;
      else if (w_is_i) w_s2imm = w_imm_i;
      else if (w_is_u) w_s2imm = w_imm_u;
      else if (w_is_j) w_s2imm = w_imm_j;
    end
  end

  assign w_s1  = w_s1en ? w_rs1 : '0;
  assign w_dec = {i_in_pc, w_d0en, w_s1en, w_s2en, w_d0imm, w_s1, w_s2imm,
                  w_fun, w_op, w_itype, w_use_alu, w_illegal};

  // ---------------------------------------------------------------------------
  // Buffer control: M is the presented entry, K the skid entry
  // ---------------------------------------------------------------------------
  state_t        r_state, w_next_state;
  logic          r_in_ready, w_in_ready, w_out_valid;
  logic          w_in_fire, w_out_fire;
  logic [BW-1:0] r_m, r_k;
  logic [CNT_W-1:0] r_cnt;

  // A beat offered alongside flush is dropped, so it never fires.
  assign w_in_fire  = i_in_valid & w_in_ready & ~i_flush;
  assign w_out_fire = w_out_valid & i_out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != ST_TWO);
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (i_flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) w_next_state = ST_ONE;
        ST_ONE: begin
          if (w_in_fire && !w_out_fire && (SKID != 0)) w_next_state = ST_TWO;
          else if (!w_in_fire && w_out_fire)           w_next_state = ST_EMPTY;
        end
        ST_TWO:   if (w_out_fire) w_next_state = ST_ONE;
        default:  w_next_state = ST_EMPTY;
      endcase
    end
  end

  // Without the skid entry, ready must look through to the downstream ready.
  always_comb begin
    w_out_valid = (r_state != ST_EMPTY);
    w_in_ready  = (SKID != 0) ? r_in_ready : ((r_state == ST_EMPTY) | i_out_ready);
  end

  assign o_out_valid = w_out_valid;
  assign o_in_ready  = w_in_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_m <= '0;
      r_k <= '0;
    end else begin
      if (w_in_fire && ((r_state == ST_EMPTY) || ((r_state == ST_ONE) && w_out_fire)))
        r_m <= w_dec;
      else if ((r_state == ST_TWO) && w_out_fire)
        r_m <= r_k;
      if (w_in_fire && (r_state == ST_ONE) && !w_out_fire)
        r_k <= w_dec;
    end
  end

  // Counts downstream handoffs, including one coincident with flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)        r_cnt <= '0;
    else if (w_out_fire) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign {o_out_pc, o_d0en, o_s1en, o_s2en, o_d0imm, o_s1, o_s2imm,
          o_fun, o_opcode, o_itype, o_use_alu, o_illegal} = r_m;
  assign o_dec_cnt = r_cnt;

endmodule

// File: tb/tb_idu_pipe_stage.sv
// tb/tb_idu_pipe_stage.sv - Self-checking bench for idu_pipe_stage (SKID=1/CNT_W=4 and SKID=0/WIDTH=64)
module tb_idu_pipe_stage;

  typedef logic [299:0] wide_t;
  typedef struct packed {
    logic [63:0] pc;
    logic        d0en, s1en, s2en;
    logic [63:0] d0imm, s1, s2imm;
    logic [9:0]  fun;
    logic [6:0]  opcode;
    logic [5:0]  itype;
    logic        use_alu, illegal;
  } bund_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] inst;
  logic [63:0] pc;

  logic        a_in_ready, a_out_valid, a_d0en, a_s1en, a_s2en, a_use_alu, a_illegal;
  logic [31:0] a_pc, a_d0imm, a_s1, a_s2imm;
  logic [9:0]  a_fun;
  logic [6:0]  a_opcode;
  logic [5:0]  a_itype;
  logic [3:0]  a_cnt;

  logic        b_in_ready, b_out_valid, b_d0en, b_s1en, b_s2en, b_use_alu, b_illegal;
  logic [63:0] b_pc, b_d0imm, b_s1, b_s2imm;
  logic [9:0]  b_fun;
  logic [6:0]  b_opcode;
  logic [5:0]  b_itype;
  logic [31:0] b_cnt;

  idu_pipe_stage #(.WIDTH(32), .SKID(1), .CNT_W(4)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
    .o_in_ready(a_in_ready), .i_in_inst(inst), .i_in_pc(pc[31:0]),
    .o_out_valid(a_out_valid), .i_out_ready(out_ready), .o_out_pc(a_pc),
    .o_d0en(a_d0en), .o_s1en(a_s1en), .o_s2en(a_s2en), .o_d0imm(a_d0imm),
    .o_s1(a_s1), .o_s2imm(a_s2imm), .o_fun(a_fun), .o_opcode(a_opcode),
    .o_itype(a_itype), .o_use_alu(a_use_alu), .o_illegal(a_illegal), .o_dec_cnt(a_cnt)
  );

  idu_pipe_stage #(.WIDTH(64), .SKID(0), .CNT_W(32)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
    .o_in_ready(b_in_ready), .i_in_inst(inst), .i_in_pc(pc),
    .o_out_valid(b_out_valid), .i_out_ready(out_ready), .o_out_pc(b_pc),
    .o_d0en(b_d0en), .o_s1en(b_s1en), .o_s2en(b_s2en), .o_d0imm(b_d0imm),
    .o_s1(b_s1), .o_s2imm(b_s2imm), .o_fun(b_fun), .o_opcode(b_opcode),
    .o_itype(b_itype), .o_use_alu(b_use_alu), .o_illegal(b_illegal), .o_dec_cnt(b_cnt)
  );

  bund_t obs_a, obs_b;
  assign obs_a = {32'b0, a_pc, a_d0en, a_s1en, a_s2en, 32'b0, a_d0imm, 32'b0, a_s1,
                  32'b0, a_s2imm, a_fun, a_opcode, a_itype, a_use_alu, a_illegal};
  assign obs_b = {b_pc, b_d0en, b_s1en, b_s2en, b_d0imm, b_s1, b_s2imm,
                  b_fun, b_opcode, b_itype, b_use_alu, b_illegal};

  int tests = 0;
  int fails = 0;
  bund_t qa[$];
  bund_t qb[$];
  int unsigned cnt_a = 0;
  int unsigned cnt_b = 0;
  logic [6:0] ops [12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                           7'b1110011, 7'b0110111, 7'b0010111, 7'b0100011,
                           7'b1100011, 7'b1101111, 7'b0110011, 7'b0001111};

  task automatic chk(input string tag, input wide_t obs, input wide_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Interpret 'v' as a two's-complement number of 'bits' bits.
  function automatic logic [63:0] sx(input longint v, input int bits);
    longint lim;
    lim = longint'(1) << (bits - 1);
    if (v >= lim) v = v - (lim << 1);
    return 64'(v);
  endfunction

  function automatic bund_t ref_dec(input logic [31:0] ins, input logic [63:0] p);
    bund_t b;
    logic [63:0] rd, rs1, rs2, imm_i, imm_s, imm_b, imm_u, imm_j;
    b = '0;
    b.pc = p;
    b.fun = {ins[14:12], ins[31:25]};
    b.opcode = ins[6:0];
    rd  = 64'(ins[11:7]);
    rs1 = 64'(ins[19:15]);
    rs2 = 64'(ins[24:20]);
    imm_i = sx(longint'(ins[31:20]), 12);
    imm_s = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
    imm_b = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
               longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
    imm_u = sx(longint'(ins[31:12]) * 4096, 32);
    imm_j = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
               longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
    case (ins[6:0])
      7'b0110011:
        if (ins[31:25] == 7'd0 || ins[31:25] == 7'd32) begin
          b.itype = 6'b100000; b.d0en = 1; b.s1en = 1; b.s2en = 1; b.use_alu = 1;
          b.d0imm = rd; b.s1 = rs1; b.s2imm = rs2;
        end else b.illegal = 1;
      7'b0010011, 7'b0000011, 7'b1100111: begin
        b.itype = 6'b010000; b.d0en = 1; b.s1en = 1;
        b.d0imm = rd; b.s1 = rs1; b.s2imm = imm_i;
        b.use_alu = (ins[6:0] == 7'b0010011);
      end
      7'b1110011: begin b.itype = 6'b010000; b.s2imm = imm_i; end
      7'b0100011: begin
        b.itype = 6'b001000; b.s1en = 1; b.s2en = 1;
        b.d0imm = imm_s; b.s1 = rs1; b.s2imm = rs2;
      end
      7'b1100011: begin
        b.itype = 6'b000100; b.s1en = 1; b.s2en = 1;
        b.d0imm = imm_b; b.s1 = rs1; b.s2imm = rs2;
      end
      7'b0110111, 7'b0010111: begin
        b.itype = 6'b000010; b.d0en = 1; b.s1en = 1;
        b.d0imm = rd; b.s1 = rs1; b.s2imm = imm_u;
      end
      7'b1101111: begin b.itype = 6'b000001; b.d0en = 1; b.d0imm = rd; b.s2imm = imm_j; end
      default: b.illegal = 1;
    endcase
    return b;
  endfunction

  function automatic bund_t t32(input bund_t b);
    b.pc[63:32] = '0; b.d0imm[63:32] = '0; b.s1[63:32] = '0; b.s2imm[63:32] = '0;
    return b;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int k;
    k = int'($urandom % 13);
    r = $urandom;
    if (k < 12) begin
      r[6:0] = ops[k];
      if (r[6:0] == 7'b0110011 && ($urandom % 4) != 0)
        r[31:25] = (($urandom % 2) != 0) ? 7'b0100000 : 7'b0000000;
    end
    return r;
  endfunction

  // One clock: drive at negedge, check at negedge+1, advance the model at posedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] p,
                      input logic ordy, input logic fl);
    bit ea_rdy, eb_rdy, a_of, b_of, a_if, b_if;
    bund_t d;
    @(negedge clk);
    in_valid = v; inst = ins; pc = p; out_ready = ordy; flush = fl;
    #1;
    ea_rdy = (qa.size() < 2);
    eb_rdy = (qb.size() == 0) || ordy;
    chk("a_in_ready", wide_t'(a_in_ready), wide_t'(ea_rdy));
    chk("a_out_valid", wide_t'(a_out_valid), wide_t'(qa.size() != 0));
    if (qa.size() != 0) chk("a_bundle", wide_t'(obs_a), wide_t'(t32(qa[0])));
    chk("a_dec_cnt", wide_t'(a_cnt), wide_t'(cnt_a[3:0]));
    chk("b_in_ready", wide_t'(b_in_ready), wide_t'(eb_rdy));
    chk("b_out_valid", wide_t'(b_out_valid), wide_t'(qb.size() != 0));
    if (qb.size() != 0) chk("b_bundle", wide_t'(obs_b), wide_t'(qb[0]));
    chk("b_dec_cnt", wide_t'(b_cnt), wide_t'(cnt_b));
    d = ref_dec(ins, p);
    a_of = (qa.size() != 0) && ordy;
    b_of = (qb.size() != 0) && ordy;
    a_if = v && ea_rdy && !fl;
    b_if = v && eb_rdy && !fl;
    @(posedge clk);
    if (a_of) begin void'(qa.pop_front()); cnt_a = (cnt_a + 1) % 16; end
    if (b_of) begin void'(qb.pop_front()); cnt_b = cnt_b + 1; end
    if (fl) begin qa.delete(); qb.delete(); end
    else begin
      if (a_if) qa.push_back(d);
      if (b_if) qb.push_back(d);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a_valid"}, wide_t'(a_out_valid), wide_t'(1'b0));
    chk({tag, "_a_ready"}, wide_t'(a_in_ready), wide_t'(1'b1));
    chk({tag, "_a_bundle"}, wide_t'(obs_a), wide_t'(0));
    chk({tag, "_a_cnt"}, wide_t'(a_cnt), wide_t'(0));
    chk({tag, "_b_valid"}, wide_t'(b_out_valid), wide_t'(1'b0));
    chk({tag, "_b_bundle"}, wide_t'(obs_b), wide_t'(0));
    chk({tag, "_b_cnt"}, wide_t'(b_cnt), wide_t'(0));
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inst = '0; pc = '0;
    #2 rst_n = 1'b0;
    #2 chk_reset_vals("reset");
    @(negedge clk); rst_n = 1'b1;

    // 17 accepted beats then one drain cycle: 17 handoffs, CNT_W=4 wraps to 1.
    step(1, 32'hFFF08293, 64'h1000, 1, 0);
    #1;
    chk("addi_valid", wide_t'(a_out_valid), wide_t'(1'b1));
    chk("addi_itype", wide_t'(a_itype), wide_t'(6'b010000));
    chk("addi_d0imm", wide_t'(a_d0imm), wide_t'(32'd5));
    chk("addi_s1", wide_t'(a_s1), wide_t'(32'd1));
    chk("addi_s2imm", wide_t'(a_s2imm), wide_t'(32'hFFFFFFFF));
    chk("addi_s2imm64", wide_t'(b_s2imm), wide_t'(64'hFFFFFFFFFFFFFFFF));
    chk("addi_use_alu", wide_t'(a_use_alu), wide_t'(1'b1));
    step(1, 32'h0021A423, 64'h1004, 1, 0);
    #1;
    chk("sw_d0en", wide_t'(a_d0en), wide_t'(1'b0));
    chk("sw_d0imm", wide_t'(a_d0imm), wide_t'(32'd8));
    chk("sw_s1", wide_t'(a_s1), wide_t'(32'd3));
    chk("sw_s2en", wide_t'(a_s2en), wide_t'(1'b1));
    chk("sw_s2imm", wide_t'(a_s2imm), wide_t'(32'd2));
    chk("sw_itype", wide_t'(a_itype), wide_t'(6'b001000));
    step(1, 32'h00000000, 64'h1008, 1, 0);
    #1;
    chk("zero_illegal", wide_t'(a_illegal), wide_t'(1'b1));
    chk("zero_itype", wide_t'(a_itype), wide_t'(6'b0));
    chk("zero_enables", wide_t'({a_d0en, a_s1en, a_s2en, a_use_alu}), wide_t'(4'b0));
    step(1, 32'h02000033, 64'h100C, 1, 0);
    #1;
    chk("f7_illegal", wide_t'(a_illegal), wide_t'(1'b1));
    chk("f7_itype", wide_t'(a_itype), wide_t'(6'b0));
    chk("f7_enables", wide_t'({a_d0en, a_s1en, a_s2en, a_use_alu}), wide_t'(4'b0));
    for (int i = 0; i < 13; i++) step(1, rand_inst(), {$urandom, $urandom}, 1, 0);
    step(0, 32'h0, 64'h0, 1, 0);
    #1;
    chk("cnt_wrap_a", wide_t'(a_cnt), wide_t'(4'd1));
    chk("cnt_b", wide_t'(b_cnt), wide_t'(32'd17));

    // Skid: three beats against a stalled sink, then drain.
    step(1, 32'h00100093, 64'h2000, 0, 0);
    step(1, 32'h00200113, 64'h2004, 0, 0);
    #1;
    chk("skid_full_ready", wide_t'(a_in_ready), wide_t'(1'b0));
    step(1, 32'h00300193, 64'h2008, 0, 0);
    step(0, 32'h0, 64'h0, 1, 0);
    step(0, 32'h0, 64'h0, 1, 0);
    #1;
    chk("skid_drained", wide_t'(a_out_valid), wide_t'(1'b0));

    // Flush while both entries are occupied.
    step(1, 32'h00400213, 64'h3000, 0, 0);
    step(1, 32'h00500293, 64'h3004, 0, 0);
    step(1, 32'h00600313, 64'h3008, 0, 1);
    #1;
    chk("flush_valid", wide_t'(a_out_valid), wide_t'(1'b0));
    chk("flush_ready", wide_t'(a_in_ready), wide_t'(1'b1));
    chk("flush_cnt", wide_t'(a_cnt), wide_t'(cnt_a[3:0]));

    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, rand_inst(), {$urandom, $urandom},
           ($urandom % 3) != 0, ($urandom % 25) == 0);

    // Asynchronous reset mid-stream.
    step(1, rand_inst(), 64'h4000, 0, 0);
    step(1, rand_inst(), 64'h4004, 0, 0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 40; i++)
      step(($urandom % 4) != 0, rand_inst(), {$urandom, $urandom}, ($urandom % 3) != 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
